// File: rtl/ps2_keycode_rx_if.sv
// Keycode event bus between the PS/2 receiver (master) and the game logic (slave).
interface ps2_keycode_rx_if;
  logic [7:0] keycode;
  logic       keyPress;
  logic       extended;
  logic       codeValid;
  logic       frameError;

  modport master (
    output keycode,
    output keyPress,
    output extended,
    output codeValid,
    output frameError
  );

  modport slave (
    input keycode,
    input keyPress,
    input extended,
    input codeValid,
    input frameError
  );
endinterface

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: pin sync + clock deglitch, 11-bit frame FSM, E0/F0 prefix folding.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
//
// state    | meaning
// S_IDLE   | waiting for a start bit (data 0 on a filtered falling edge)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | capturing the parity bit
// S_STOP   | checking stop bit (and parity), completing or rejecting the byte
module ps2_keycode_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_keycode_rx_if.master kc_o
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic [7:0]  FLT_LEN  = 8'(FILTER_LEN);
  localparam logic [20:0] TO_LAST  = 21'(TIMEOUT_CYCLES - 1);
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic       clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic       filt_q, filt_d;
  logic [7:0] run_q, run_d;
  logic       fall_q, fall_d;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [20:0] to_cnt_q, to_cnt_d;
  logic        timeout_w;

  logic       byte_ok_w, frame_bad_w, parity_ok_w;
  logic [7:0] keycode_q, keycode_d;
  logic       press_q, press_d;
  logic       extd_q, extd_d;
  logic       cv_q, cv_d;
  logic       fe_q, fe_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;

  // Synchronizers and the clock filter idle high so reset looks like an idle bus.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      filt_q     <= 1'b1;
      run_q      <= '0;
      fall_q     <= 1'b0;
    end else begin
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_data;
      dat_sync_q <= dat_meta_q;
      filt_q     <= filt_d;
      run_q      <= run_d;
      fall_q     <= fall_d;
    end
  end

  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    if (clk_sync_q != filt_q) begin
      if (run_q + 8'd1 == FLT_LEN) begin
        filt_d = clk_sync_q;
      end else begin
        run_d = run_q + 8'd1;
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  // Frame FSM: state register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign timeout_w = (state_q != S_IDLE) && !fall_q && (to_cnt_q == TO_LAST);

  // Frame FSM: next state
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    if (state_q == S_IDLE || fall_q) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 21'd1;
    end
    case (state_q)
      S_IDLE: begin
        if (fall_q && !dat_sync_q) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (fall_q) begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fall_q) begin
          par_d   = dat_sync_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fall_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout_w) begin
      state_d  = S_IDLE;
      to_cnt_d = '0;
    end
  end

  assign parity_ok_w = (^{shift_q, par_q}) | ~PARITY_EN;

  // Frame FSM: outputs
  always_comb begin
    byte_ok_w   = 1'b0;
    frame_bad_w = 1'b0;
    if (state_q == S_STOP && fall_q) begin
      if (dat_sync_q && parity_ok_w) begin
        byte_ok_w = 1'b1;
      end else begin
        frame_bad_w = 1'b1;
      end
    end
  end

  // Prefix folding: E0/F0 only arm flags; any other byte emits one event.
  always_comb begin
    keycode_d = keycode_q;
    press_d   = press_q;
    extd_d    = extd_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    cv_d      = 1'b0;
    fe_d      = 1'b0;
    if (byte_ok_w) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        keycode_d = shift_q;
        press_d   = ~brk_q;
        extd_d    = ext_q;
        cv_d      = 1'b1;
        ext_d     = 1'b0;
        brk_d     = 1'b0;
      end
    end else if (frame_bad_w) begin
      fe_d  = 1'b1;
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      keycode_q <= '0;
      press_q   <= 1'b0;
      extd_q    <= 1'b0;
      cv_q      <= 1'b0;
      fe_q      <= 1'b0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      keycode_q <= keycode_d;
      press_q   <= press_d;
      extd_q    <= extd_d;
      cv_q      <= cv_d;
      fe_q      <= fe_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
    end
  end

  assign kc_o.keycode    = keycode_q;
  assign kc_o.keyPress   = press_q;
  assign kc_o.extended   = extd_q;
  assign kc_o.codeValid  = cv_q;
  assign kc_o.frameError = fe_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: table of frames with expected events, scoreboard monitor, corner sequences.
module tb_ps2_keycode_rx;
  localparam int HP = 30;           // PS/2 half period in Clk cycles
  localparam int TO = 2000;

  typedef struct {
    logic [7:0] data;
    bit         bad_par;
    bit         stop;
    bit         ev;
    bit         err;
    logic [7:0] kc;
    bit         press;
    bit         ext;
  } vec_t;

  typedef struct {
    bit         err;
    logic [7:0] kc;
    bit         press;
    bit         ext;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  always #5 Clk = ~Clk;

  ps2_keycode_rx_if kc_if ();

  ps2_keycode_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kc_o     (kc_if)
  );

  int nchecks = 0;
  int nerr = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] last_kc = 8'h00;
  bit last_press = 1'b0;
  bit last_ext = 1'b0;
  bit prev_pulse = 1'b0;
  vec_t tbl[17];

  task automatic chk(input string nm, input int act, input int req);
    nchecks++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic ps2_bit(input bit b);
    ps2_data = b;
    cyc(HP);
    ps2_clk = 1'b0;
    cyc(HP);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop);
    bit p;
    p = (~^d) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
    ps2_bit(stop);
  endtask

  task automatic push_exp(input bit err, input logic [7:0] kc, input bit press, input bit ext);
    exp_t e;
    e.err = err; e.kc = kc; e.press = press; e.ext = ext;
    sb.push_back(e);
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_drained"}, sb.size(), 0);
    chk({tag, "_keycode"}, kc_if.keycode, last_kc);
    chk({tag, "_keyPress"}, kc_if.keyPress, last_press);
    chk({tag, "_extended"}, kc_if.extended, last_ext);
  endtask

  // Scoreboard: every pulse must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (Reset) begin
      if (kc_if.codeValid || kc_if.frameError) begin
        chk("pulse_exclusive", kc_if.codeValid & kc_if.frameError, 0);
        chk("pulse_width", prev_pulse, 0);
        if (sb.size() == 0) begin
          nchecks++;
          nerr++;
          $display("FAIL unexpected_event: codeValid=%0b frameError=%0b keycode=%0h, required no event",
                   kc_if.codeValid, kc_if.frameError, kc_if.keycode);
        end else begin
          mon_e = sb.pop_front();
          chk("event_is_error", kc_if.frameError, mon_e.err);
          if (mon_e.err) begin
            chk("err_hold_keycode", kc_if.keycode, last_kc);
            chk("err_hold_keyPress", kc_if.keyPress, last_press);
            chk("err_hold_extended", kc_if.extended, last_ext);
          end else begin
            chk("ev_keycode", kc_if.keycode, mon_e.kc);
            chk("ev_keyPress", kc_if.keyPress, mon_e.press);
            chk("ev_extended", kc_if.extended, mon_e.ext);
            last_kc = mon_e.kc;
            last_press = mon_e.press;
            last_ext = mon_e.ext;
          end
        end
      end
      prev_pulse = kc_if.codeValid | kc_if.frameError;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit found;

    //            data   badp stop ev err kc     press ext
    tbl[0]  = '{8'h1D, 0, 1, 1, 0, 8'h1D, 1, 0};
    tbl[1]  = '{8'hF0, 0, 1, 0, 0, 8'h00, 0, 0};
    tbl[2]  = '{8'h1D, 0, 1, 1, 0, 8'h1D, 0, 0};
    tbl[3]  = '{8'hE0, 0, 1, 0, 0, 8'h00, 0, 0};
    tbl[4]  = '{8'hF0, 0, 1, 0, 0, 8'h00, 0, 0};
    tbl[5]  = '{8'h75, 0, 1, 1, 0, 8'h75, 0, 1};
    tbl[6]  = '{8'h75, 0, 1, 1, 0, 8'h75, 1, 0};
    tbl[7]  = '{8'hF0, 0, 1, 0, 0, 8'h00, 0, 0};
    tbl[8]  = '{8'hE0, 0, 1, 0, 0, 8'h00, 0, 0};
    tbl[9]  = '{8'h6B, 0, 1, 1, 0, 8'h6B, 0, 1};
`ifdef PS2_PARITY_CHECK_EN
    tbl[10] = '{8'h1D, 1, 1, 1, 1, 8'h00, 0, 0};
    tbl[12] = '{8'h1D, 1, 1, 1, 1, 8'h00, 0, 0};
`else
    tbl[10] = '{8'h1D, 1, 1, 1, 0, 8'h1D, 1, 0};
    tbl[12] = '{8'h1D, 1, 1, 1, 0, 8'h1D, 1, 1};
`endif
    tbl[11] = '{8'hE0, 0, 1, 0, 0, 8'h00, 0, 0};
    tbl[13] = '{8'h1C, 0, 1, 1, 0, 8'h1C, 1, 0};
    tbl[14] = '{8'hE0, 0, 1, 0, 0, 8'h00, 0, 0};
    tbl[15] = '{8'h29, 0, 0, 1, 1, 8'h00, 0, 0};
    tbl[16] = '{8'h29, 0, 1, 1, 0, 8'h29, 1, 0};

    cyc(5);
    chk("rst_keycode", kc_if.keycode, 8'h00);
    chk("rst_keyPress", kc_if.keyPress, 0);
    chk("rst_extended", kc_if.extended, 0);
    chk("rst_codeValid", kc_if.codeValid, 0);
    chk("rst_frameError", kc_if.frameError, 0);
    Reset = 1'b1;
    cyc(5);

    // Frames run back to back: the next start bit follows the stop bit at normal bit spacing.
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].ev) push_exp(tbl[i].err, tbl[i].kc, tbl[i].press, tbl[i].ext);
      send_frame(tbl[i].data, tbl[i].bad_par, tbl[i].stop);
      chk_held($sformatf("vec%0d", i));
    end

    // Latency from stop-bit falling edge on the pin to codeValid.
    push_exp(0, 8'h1C, 1, 0);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(tbl[13].data[i]);
    ps2_bit(~^tbl[13].data);
    ps2_data = 1'b1;
    cyc(HP);
    ps2_clk = 1'b0;
    lat = 0;
    found = 1'b0;
    for (int n = 1; n <= 40 && !found; n++) begin
      @(posedge Clk);
      #1;
      if (kc_if.codeValid) begin
        found = 1'b1;
        lat = n;
      end
    end
    chk("latency", lat, 11);
    cyc(HP);
    ps2_clk = 1'b1;
    cyc(HP);
    chk_held("latency");

    // Short low glitches with data low must not start a frame.
    ps2_data = 1'b0;
    for (int g = 0; g < 6; g++) begin
      ps2_clk = 1'b0;
      cyc(3);
      ps2_clk = 1'b1;
      cyc(12);
    end
    ps2_data = 1'b1;
    cyc(20);
    push_exp(0, 8'h1C, 1, 0);
    send_frame(8'h1C, 0, 1);
    chk_held("glitch");

    // Partial frame then silence: timeout must drop it silently.
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(tbl[0].data[i]);
    cyc(TO + 500);
    chk_held("timeout_silent");
    push_exp(0, 8'h1C, 1, 0);
    send_frame(8'h1C, 0, 1);
    chk_held("timeout_next");

    // Reset mid-frame, then the tail of the interrupted frame, then F0 1C.
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(tbl[0].data[i]);
    Reset = 1'b0;
    #1;
    chk("midrst_keycode", kc_if.keycode, 8'h00);
    chk("midrst_keyPress", kc_if.keyPress, 0);
    chk("midrst_extended", kc_if.extended, 0);
    chk("midrst_codeValid", kc_if.codeValid, 0);
    chk("midrst_frameError", kc_if.frameError, 0);
    last_kc = 8'h00;
    last_press = 1'b0;
    last_ext = 1'b0;
    cyc(5);
    Reset = 1'b1;
    cyc(3);
    for (int i = 4; i < 8; i++) ps2_bit(tbl[0].data[i]);
    ps2_bit(~^tbl[0].data);
    ps2_bit(1'b1);
    cyc(TO + 500);
    chk_held("midrst_tail");
    push_exp(0, 8'h1C, 0, 0);
    send_frame(8'hF0, 0, 1);
    send_frame(8'h1C, 0, 1);
    chk_held("midrst_next");

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule

// File: doc/ps2_keycode_rx.md
# ps2_keycode_rx

Receives the PS/2 keyboard serial stream on the raw `ps2_clk`/`ps2_data` pins and turns it into the `keycode`/`keyPress` pair that the game logic consumes. It synchronizes and deglitches the pins, deserializes 11-bit device-to-host frames, and folds the `E0` (extended) and `F0` (break) prefixes into a single event per key. The block is the producing end of the keycode interface and sits between the board pins and the player and game-state logic.

## Interface
- `FILTER_LEN`, 8: consecutive identical synchronized samples of `ps2_clk` needed before the filtered clock changes (range 1–255).
- `TIMEOUT_CYCLES`, 50000: idle `Clk` cycles within a frame before the frame is abandoned (1 ms at 50 MHz; range 2–2^20).
- `Clk` input 1: system clock; all state is on its rising edge.
- `Reset` input 1: asynchronous, active-low reset.
- `ps2_clk` input 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` input 1: raw PS/2 data pin, asynchronous.
- `keycode` output 8: last completed scan code, prefixes removed; holds its value between events.
- `keyPress` output 1: 1 = make, 0 = break for `keycode`; holds.
- `extended` output 1: 1 if the last event was `E0`-prefixed; holds.
- `codeValid` output 1: one-cycle pulse when `keycode`/`keyPress`/`extended` update.
- `frameError` output 1: one-cycle pulse on a rejected frame.

## Operation
- Both pins pass through a 2-flop synchronizer. A run counter then filters `ps2_clk`: the filtered clock takes the new synchronized value after `FILTER_LEN` consecutive equal samples. The data pin is synchronized only.
- A falling edge is a filtered-clock 1→0 transition. On that cycle, sample the synchronized data bit.
- Frame FSM:
  - IDLE: on a falling edge, data 0 → DATA with bit count 0. Data 1 → stay in IDLE and ignore.
  - DATA: shift data in LSB first. After the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: data 1 and parity OK → byte complete. Otherwise pulse `frameError`. Either way → IDLE.
- Parity is odd: the 8 data bits plus the parity bit contain an odd number of ones.
- Timeout: a counter clears on every falling edge and increments in any state other than IDLE. On reaching `TIMEOUT_CYCLES`, return to IDLE and discard the partial byte. No `frameError` pulse is produced.
- Byte decode on completion:
  - `E0` sets the ext flag. No output change.
  - `F0` sets the brk flag. No output change.
  - Any other byte: `keycode`←byte, `keyPress`←~brk, `extended`←ext, pulse `codeValid`, then clear both flags.
- A rejected frame also clears ext and brk.
- `E0 F0 xx` and `F0 E0 xx` both yield `extended`=1, `keyPress`=0.
- The block never drives the pins. Host-to-device traffic is out of scope.

## Timing
- Reset values: `keycode`=8'h00, `keyPress`=0, `extended`=0, `codeValid`=0, `frameError`=0. FSM in IDLE, flags clear. Filtered clock and both synchronizer chains reset to 1 (bus idle).
- Latency from the stop-bit falling edge on the pin to `codeValid`: 2 (sync) + `FILTER_LEN` + 1 `Clk` cycles. Outputs update on the same edge that raises `codeValid`.
- `codeValid` and `frameError` are each exactly one cycle wide and are never asserted together.
- The filtered clock toggles at most once per `FILTER_LEN` cycles. Glitches shorter than `FILTER_LEN` cycles are ignored.
- Reset deasserted mid-frame: the block starts in IDLE. The remaining bits of the interrupted frame are either ignored (no start bit) or time out, and the next clean frame decodes.
- Back-to-back frames with no idle gap are accepted: IDLE is re-entered on the cycle after STOP.

## Configuration
- `PS2_PARITY_CHECK_EN`:
  - Defined: a parity mismatch rejects the frame (`frameError` pulse, byte discarded, flags cleared).
  - Undefined: the parity bit is sampled and ignored, and only a stop bit of 0 rejects a frame.

## Test plan
- Make code: frame 0x1D (data bits 1,0,1,1,1,0,0,0, parity 1, stop 1) at 12.5 kHz → one `codeValid` pulse; `keycode`=8'h1D, `keyPress`=1, `extended`=0.
- Break code: frames F0 then 1D → exactly one `codeValid` pulse, after the second frame only; `keycode`=8'h1D, `keyPress`=0. Both flags are clear afterwards.
- Extended code: frames E0, F0, 75 → `keycode`=8'h75, `extended`=1, `keyPress`=0. A following plain 75 gives `extended`=0, `keyPress`=1.
- Bad parity: 0x1D sent with parity 0, with `PS2_PARITY_CHECK_EN` defined → `frameError` pulse, no `codeValid`, outputs unchanged. Without the macro → `codeValid` with `keycode`=8'h1D.
- Glitch and timeout:
  - 3-cycle low pulses on `ps2_clk` (`FILTER_LEN`=8) → no state change.
  - 5 bits of a frame followed by silence longer than `TIMEOUT_CYCLES` → back in IDLE; the next 0x1C frame decodes cleanly.
- Reset mid-frame: assert `Reset`=0 after bit 4 of a frame → all outputs 0 immediately. After release, the next F0, 1C sequence yields `keycode`=8'h1C, `keyPress`=0.
